// File: rtl/iaoq_sequencer.sv
// IAOQ front/back sequencer for the fetch stage: delayed-branch advance, stall hold, flush redirect.
// Optional build macro IAOQ_STALL_COUNT_EN adds a saturating stall_cycles counter output.
module iaoq_sequencer #(
  parameter int AW         = 8,
  parameter int STEP       = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          flush,
  input  logic [AW-1:0] flush_addr,
  output logic [AW-1:0] iaoq_front,
  output logic [AW-1:0] iaoq_back,
  output logic          front_le,
  output logic          fetch_valid,
`ifdef IAOQ_STALL_COUNT_EN
  output logic [7:0]    stall_cycles,
`endif
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_ADV   = 2'd1,
    SEL_REDIR = 2'd2
  } sel_t;

  localparam logic [AW-1:0] STEP_W  = AW'(STEP);
  localparam logic [AW-1:0] RST_FRONT = AW'(RESET_ADDR);
  localparam logic [AW-1:0] RST_BACK  = AW'(RESET_ADDR + STEP);

  state_t        state_q, state_d;
  sel_t          sel;
  logic [AW-1:0] front_q, front_d;
  logic [AW-1:0] back_q, back_d;

  // Priority in every active state is flush > stall > advance; IDLE only honours flush and start.
  always_comb begin
    state_d = state_q;
    sel     = SEL_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (flush)      sel = SEL_REDIR;
        else if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush) begin
          sel     = SEL_REDIR;
          state_d = ST_FLUSH;
        end else if (stall) begin
          state_d = ST_STALL;
        end else begin
          sel = SEL_ADV;
        end
      end
      ST_STALL: begin
        if (flush) begin
          sel     = SEL_REDIR;
          state_d = ST_FLUSH;
        end else if (!stall) begin
          sel     = SEL_ADV;
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (flush) sel = SEL_REDIR;
        else       state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    front_d = front_q;
    back_d  = back_q;
    case (sel)
      SEL_ADV: begin
        front_d = back_q;
        back_d  = br_taken ? br_target : back_q + STEP_W;
      end
      SEL_REDIR: begin
        front_d = flush_addr;
        back_d  = flush_addr + STEP_W;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      front_q <= RST_FRONT;
      back_q  <= RST_BACK;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      back_q  <= back_d;
    end
  end

  assign iaoq_front  = front_q;
  assign iaoq_back   = back_q;
  assign state       = state_q;
  assign fetch_valid = (state_q == ST_RUN);
  assign front_le    = reset && (sel != SEL_HOLD);

`ifdef IAOQ_STALL_COUNT_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;

  // A flush clears the count even when it arrives while stalled.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush)
      stall_cnt_d = 8'h00;
    else if (state_q == ST_STALL && stall_cnt_q != 8'hFF)
      stall_cnt_d = stall_cnt_q + 8'h01;
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= 8'h00;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_iaoq_sequencer.sv
// Directed self-checking bench for iaoq_sequencer; covers IAOQ_STALL_COUNT_EN when that macro is defined.
module tb_iaoq_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stall;
  logic       br_taken;
  logic [7:0] br_target;
  logic       flush;
  logic [7:0] flush_addr;
  logic [7:0] iaoq_front;
  logic [7:0] iaoq_back;
  logic       front_le;
  logic       fetch_valid;
  logic [1:0] state;
`ifdef IAOQ_STALL_COUNT_EN
  logic [7:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];

  iaoq_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .iaoq_front  (iaoq_front),
    .iaoq_back   (iaoq_back),
    .front_le    (front_le),
    .fetch_valid (fetch_valid),
`ifdef IAOQ_STALL_COUNT_EN
    .stall_cycles(stall_cycles),
`endif
    .state       (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic st, input logic bt, input logic [7:0] bta,
                       input logic fl, input logic [7:0] fa);
    start = s; stall = st; br_taken = bt; br_target = bta; flush = fl; flush_addr = fa;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 8'h66);
    checks++; if (front_le !== 1'b0) begin errors++; $display("FAIL reset_front_le got=%b exp=0", front_le); end
    tick(); tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h00, 8'h04, 2'd0}) begin errors++;
      $display("FAIL reset_state got=%h/%h/%0d exp=00/04/0", iaoq_front, iaoq_back, state); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got=%b exp=0", fetch_valid); end
  endtask

  task automatic test_start();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checks++; if ({front_le, fetch_valid} !== 2'b00) begin errors++; $display("FAIL idle_start_le_fv got=%b exp=00", {front_le, fetch_valid}); end
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h00, 8'h04, 2'd1}) begin errors++;
      $display("FAIL start_run got=%h/%h/%0d exp=00/04/1", iaoq_front, iaoq_back, state); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checks++; if ({front_le, fetch_valid} !== 2'b11) begin errors++; $display("FAIL run_le_fv got=%b exp=11", {front_le, fetch_valid}); end
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h04, 8'h08, 2'd1}) begin errors++;
      $display("FAIL seq_step1 got=%h/%h/%0d exp=04/08/1", iaoq_front, iaoq_back, state); end
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h08, 8'h0C, 2'd1}) begin errors++;
      $display("FAIL seq_step2 got=%h/%h/%0d exp=08/0c/1", iaoq_front, iaoq_back, state); end
  endtask

  task automatic test_branch();
    drive(1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h0C, 8'h40, 2'd1}) begin errors++;
      $display("FAIL branch_delay got=%h/%h/%0d exp=0c/40/1", iaoq_front, iaoq_back, state); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h40, 8'h44, 2'd1}) begin errors++;
      $display("FAIL branch_target got=%h/%h/%0d exp=40/44/1", iaoq_front, iaoq_back, state); end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state, fetch_valid} !== {8'h10, 8'h14, 2'd3, 1'b0}) begin errors++;
      $display("FAIL flush_to_16 got=%h/%h/%0d fv=%b exp=10/14/3 fv=0", iaoq_front, iaoq_back, state, fetch_valid); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checks++; if (front_le !== 1'b0) begin errors++; $display("FAIL flush_bubble_le got=%b exp=0", front_le); end
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h10, 8'h14, 2'd1}) begin errors++;
      $display("FAIL bubble_to_run got=%h/%h/%0d exp=10/14/1", iaoq_front, iaoq_back, state); end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state, front_le, fetch_valid} !== {8'h10, 8'h14, 2'd2, 2'b00}) begin errors++;
      $display("FAIL stall_enter got=%h/%h/%0d le_fv=%b exp=10/14/2 le_fv=00", iaoq_front, iaoq_back, state, {front_le, fetch_valid}); end
    tick(); tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h10, 8'h14, 2'd2}) begin errors++;
      $display("FAIL stall_hold got=%h/%h/%0d exp=10/14/2", iaoq_front, iaoq_back, state); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checks++; if (front_le !== 1'b1) begin errors++; $display("FAIL stall_release_le got=%b exp=1", front_le); end
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h14, 8'h18, 2'd1}) begin errors++;
      $display("FAIL stall_release got=%h/%h/%0d exp=14/18/1", iaoq_front, iaoq_back, state); end
`ifdef IAOQ_STALL_COUNT_EN
    checks++; if (stall_cycles !== 8'd3) begin errors++; $display("FAIL stall_count got=%0d exp=3", stall_cycles); end
`endif
  endtask

  task automatic test_flush_priority();
    drive(1'b0, 1'b1, 1'b1, 8'h20, 1'b1, 8'h80);
    checks++; if (front_le !== 1'b1) begin errors++; $display("FAIL flush_le got=%b exp=1", front_le); end
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h80, 8'h84, 2'd3}) begin errors++;
      $display("FAIL flush_prio got=%h/%h/%0d exp=80/84/3", iaoq_front, iaoq_back, state); end
    drive(1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 8'h00);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h80, 8'h84, 2'd1}) begin errors++;
      $display("FAIL flush_one_cycle got=%h/%h/%0d exp=80/84/1", iaoq_front, iaoq_back, state); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h84, 8'h88, 2'd1}) begin errors++;
      $display("FAIL after_flush got=%h/%h/%0d exp=84/88/1", iaoq_front, iaoq_back, state); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hC0);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'hC0, 8'hC4, 2'd3}) begin errors++;
      $display("FAIL flush_in_flush got=%h/%h/%0d exp=c0/c4/3", iaoq_front, iaoq_back, state); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'hC0, 8'hC4, 2'd1}) begin errors++;
      $display("FAIL refetch_run got=%h/%h/%0d exp=c0/c4/1", iaoq_front, iaoq_back, state); end
`ifdef IAOQ_STALL_COUNT_EN
    checks++; if (stall_cycles !== 8'd0) begin errors++; $display("FAIL flush_clears_count got=%0d exp=0", stall_cycles); end
`endif
  endtask

  task automatic test_stall_branch();
    drive(1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 8'h00);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'hC0, 8'hC4, 2'd2}) begin errors++;
      $display("FAIL stall_drops_branch got=%h/%h/%0d exp=c0/c4/2", iaoq_front, iaoq_back, state); end
    drive(1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 8'h00);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'hC4, 8'h20, 2'd1}) begin errors++;
      $display("FAIL branch_from_stall got=%h/%h/%0d exp=c4/20/1", iaoq_front, iaoq_back, state); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h20, 8'h24, 2'd1}) begin errors++;
      $display("FAIL post_stall_branch got=%h/%h/%0d exp=20/24/1", iaoq_front, iaoq_back, state); end
  endtask

  task automatic test_wrap();
    logic [17:0] exp;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hF8);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'hF8, 8'hFC, 2'd1}) begin errors++;
      $display("FAIL wrap_setup got=%h/%h/%0d exp=f8/fc/1", iaoq_front, iaoq_back, state); end
    exp_q.push_back({8'hFC, 8'h00, 2'd1});
    exp_q.push_back({8'h00, 8'h04, 2'd1});
    exp_q.push_back({8'h04, 8'h08, 2'd1});
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      tick();
      checks++; if ({iaoq_front, iaoq_back, state} !== exp) begin errors++;
        $display("FAIL wrap_step got=%h/%h/%0d exp=%h/%h/%0d", iaoq_front, iaoq_back, state, exp[17:10], exp[9:2], exp[1:0]); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    tick(); tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pre_reset_stall got=%0d exp=2", state); end
    reset = 1'b0;
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h00, 8'h04, 2'd0}) begin errors++;
      $display("FAIL reset_mid got=%h/%h/%0d exp=00/04/0", iaoq_front, iaoq_back, state); end
`ifdef IAOQ_STALL_COUNT_EN
    checks++; if (stall_cycles !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", stall_cycles); end
`endif
  endtask

  task automatic test_idle_flush();
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 8'h30);
    checks++; if (front_le !== 1'b1) begin errors++; $display("FAIL idle_flush_le got=%b exp=1", front_le); end
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h30, 8'h34, 2'd0}) begin errors++;
      $display("FAIL idle_flush got=%h/%h/%0d exp=30/34/0", iaoq_front, iaoq_back, state); end
    drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 8'h00);
    checks++; if (front_le !== 1'b0) begin errors++; $display("FAIL idle_hold_le got=%b exp=0", front_le); end
    tick();
    checks++; if ({iaoq_front, iaoq_back, state} !== {8'h30, 8'h34, 2'd0}) begin errors++;
      $display("FAIL idle_hold got=%h/%h/%0d exp=30/34/0", iaoq_front, iaoq_back, state); end
  endtask

`ifdef IAOQ_STALL_COUNT_EN
  task automatic test_stall_saturate();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    repeat (300) tick();
    checks++; if ({state, stall_cycles} !== {2'd2, 8'hFF}) begin errors++;
      $display("FAIL stall_saturate got=%0d/%h exp=2/ff", state, stall_cycles); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    test_reset();
    test_start();
    test_branch();
    test_stall();
    test_flush_priority();
    test_stall_branch();
    test_wrap();
    test_reset_mid();
    test_idle_flush();
`ifdef IAOQ_STALL_COUNT_EN
    test_stall_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iaoq_sequencer.md
Name: iaoq_sequencer

Overview:
- Sequencing controller for the 8-bit instruction address offset queue (IAOQ) front/back pair of the PA-RISC fetch stage.
- Holds IAOQ_front (the address being fetched) and IAOQ_back (the next address), and advances them every cycle.
- Implements PA-RISC delayed-branch semantics (front <= back, back <= target), stall hold, and pipeline-flush redirect.
- Drives the fetch stage with the current address, a load-enable strobe and a fetch-valid qualifier.

Parameters:
- AW, 8, address width in bits.
- STEP, 4, sequential increment in bytes (one instruction word).
- RESET_ADDR, 0, value of iaoq_front after reset; iaoq_back resets to RESET_ADDR+STEP.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  leave IDLE and begin fetching.
- stall  in  1  hold the queue; downstream not ready.
- br_taken  in  1  taken branch resolved this cycle.
- br_target  in  AW  branch target address.
- flush  in  1  pipeline flush/redirect request.
- flush_addr  in  AW  restart address for a flush.
- iaoq_front  out  AW  current fetch address (registered).
- iaoq_back  out  AW  next fetch address (registered).
- front_le  out  1  combinational; 1 in any cycle where iaoq_front will update at the next edge.
- fetch_valid  out  1  combinational; 1 only in RUN.
- state  out  2  IDLE=0, RUN=1, STALL=2, FLUSH=3.

Behaviour:
- Reset: sampled at posedge clk while reset==0. Sets iaoq_front=RESET_ADDR, iaoq_back=RESET_ADDR+STEP and state=IDLE, so fetch_valid=0 and front_le=0. Reset overrides all other inputs, including mid-stall and mid-flush.
- All address arithmetic is modulo 2^AW. Example: back=8'hFC gives back+STEP = 8'h00.
- "Advance" is defined as:
  - If br_taken: front <= back, back <= br_target.
  - Otherwise: front <= back, back <= back+STEP.
- "Redirect" is defined as: front <= flush_addr, back <= flush_addr+STEP.
- Priority in every non-IDLE state: flush > stall > advance.
- IDLE:
  - Addresses hold.
  - start=1 -> RUN. A flush in IDLE performs a redirect and stays IDLE.
  - br_taken and stall are ignored.
- RUN:
  - flush -> redirect, next state FLUSH.
  - else stall -> hold, next state STALL.
  - else advance, stay RUN.
- STALL:
  - flush -> redirect, next state FLUSH.
  - else stall -> hold, stay STALL.
  - else advance (br_taken honoured), next state RUN.
- FLUSH (one-cycle bubble, fetch_valid=0):
  - flush again -> redirect, stay FLUSH.
  - else -> RUN with addresses held. stall and br_taken are ignored in this cycle; stall is re-evaluated in RUN.
- front_le: 1 exactly when an advance or redirect is selected this cycle; 0 on hold and in reset.
- Latency: all address and state changes are visible one clock after the inputs are sampled.
- Simultaneous flush+br_taken: the flush wins and the branch is discarded.
- Simultaneous stall+br_taken in RUN: the branch is discarded. The requester must hold br_taken until a cycle with stall=0.

Optional Feature:
- Macro: IAOQ_STALL_COUNT_EN.
- Defined:
  - Adds output stall_cycles [7:0], a saturating counter that increments on every clock where the state is STALL.
  - Saturates at 8'hFF and clears to 0 on reset or on any flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then start: reset=0 for 2 cycles, then reset=1, start=1 -> front=0, back=4, state IDLE -> RUN. Then front steps 4, 8, 12 with front_le=1 and fetch_valid=1.
- Delayed branch: in RUN with front=8, back=12, br_taken=1, br_target=8'h40 -> next cycle front=12, back=8'h40. Following cycle front=8'h40, back=8'h44.
- Stall hold: stall=1 for 3 cycles at front=16 -> state STALL, front=16/back=20 held, front_le=0, fetch_valid=0. stall=0 -> front=20, back=24, RUN. With IAOQ_STALL_COUNT_EN, stall_cycles=3.
- Flush priority: flush=1, flush_addr=8'h80, with stall=1 and br_taken=1 in the same cycle -> front=8'h80, back=8'h84, state FLUSH for exactly one cycle, then RUN.
- Wrap-around: front=8'hF8, back=8'hFC, free-running -> front=8'hFC, back=8'h00, then front=8'h00, back=8'h04.
- Reset mid-operation: reset=0 asserted while in STALL -> next edge front=0, back=4, state IDLE. Counter (if enabled) reads 0.
